// File: rtl/fft_pkg.sv
// Shared constants and types for the 64-point radix-2 FFT twiddle/address sequencer.
package fft_pkg;

   localparam int LOG2N     = 6;
   localparam int N         = 1 << LOG2N;
   localparam int N_HALF    = N / 2;
   localparam int N_QUARTER = N / 4;

   typedef logic [LOG2N-1:0]         idx_t;
   typedef logic [$clog2(LOG2N)-1:0] stage_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } gen_state_t;

endpackage

// File: rtl/fft_bfly_index.sv
// Combinational map from (stage, butterfly j) to DIT operand addresses and twiddle exponent k.
module fft_bfly_index #(
   parameter int LOG2N = fft_pkg::LOG2N,
   parameter int ST_W  = $clog2(LOG2N)
) (
   input  logic [ST_W-1:0]  s,
   input  logic [LOG2N-2:0] j,
   output logic [LOG2N-1:0] addr_top,
   output logic [LOG2N-1:0] addr_bot,
   output logic [LOG2N-1:0] k
);

   localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);
   localparam logic [ST_W-1:0]  SMAX = ST_W'(LOG2N - 1);

   logic [LOG2N-1:0] jx, half, pos, grp;

   always_comb begin
      jx       = {1'b0, j};
      half     = ONE << s;
      pos      = jx & (half - ONE);
      grp      = jx >> s;
      // group base is grp * 2 * half; pos never overlaps it, so OR is an add
      addr_top = ((grp << s) << 1) | pos;
      addr_bot = addr_top + half;
      k        = pos << (SMAX - s);
   end

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// Butterfly descriptor source (addresses + sin/cos ROM selects) for an in-place radix-2 DIT FFT.
// Optional conjugate-twiddle (inverse transform) support under macro FFT_TWIDDLE_IFFT_EN.
module fft_twiddle_addr_gen #(
   parameter int LOG2N = fft_pkg::LOG2N,
   parameter int IDX_W = LOG2N
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
`ifdef FFT_TWIDDLE_IFFT_EN
   input  logic                     inverse,
`endif
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         addr_top,
   output logic [IDX_W-1:0]         addr_bot,
   output logic [IDX_W-1:0]         sin_idx,
   output logic [IDX_W-1:0]         cos_idx,
   output logic [$clog2(LOG2N)-1:0] stage,
   output logic                     stage_last,
   output logic                     seq_last,
   output logic                     done
);

   import fft_pkg::*;

   // state | meaning
   // IDLE  | waiting for start, outputs cleared
   // RUN   | presenting descriptors, advancing on each transfer
   // DONE  | one-cycle done pulse, then back to IDLE

   localparam int ST_W = $clog2(LOG2N);
   localparam int J_W  = LOG2N - 1;
   localparam logic [J_W-1:0]   J_MAX  = {J_W{1'b1}};
   localparam logic [ST_W-1:0]  S_MAX  = ST_W'(LOG2N - 1);
   localparam logic [IDX_W-1:0] QUART  = IDX_W'(1 << (LOG2N - 2));

   gen_state_t       state;
   logic [J_W-1:0]   j, nxt_j;
   logic [ST_W-1:0]  nxt_s;
   logic [IDX_W-1:0] b_top, b_bot, b_k, nxt_sin;
   logic             nxt_stl, inv_use;

`ifdef FFT_TWIDDLE_IFFT_EN
   logic inv_q;
   assign inv_use = (state == IDLE) ? inverse : inv_q;
`else
   assign inv_use = 1'b0;
`endif

   always_comb begin
      nxt_s = stage;
      nxt_j = j + J_W'(1);
      if (state == IDLE) begin
         nxt_s = '0;
         nxt_j = '0;
      end else if (j == J_MAX) begin
         nxt_s = stage + ST_W'(1);
         nxt_j = '0;
      end
   end

   fft_bfly_index #(.LOG2N(LOG2N), .ST_W(ST_W)) u_idx (
      .s        (nxt_s),
      .j        (nxt_j),
      .addr_top (b_top),
      .addr_bot (b_bot),
      .k        (b_k)
   );

   // negating mod N gives (N - k) mod N, the conjugate twiddle
   assign nxt_sin = inv_use ? (IDX_W'(0) - b_k) : b_k;
   assign nxt_stl = (nxt_j == J_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         j          <= '0;
         stage      <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         done       <= 1'b0;
         addr_top   <= '0;
         addr_bot   <= '0;
         sin_idx    <= '0;
         cos_idx    <= '0;
         stage_last <= 1'b0;
         seq_last   <= 1'b0;
`ifdef FFT_TWIDDLE_IFFT_EN
         inv_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state      <= RUN;
               busy       <= 1'b1;
               out_valid  <= 1'b1;
               j          <= nxt_j;
               stage      <= nxt_s;
               addr_top   <= b_top;
               addr_bot   <= b_bot;
               sin_idx    <= nxt_sin;
               cos_idx    <= b_k + QUART;
               stage_last <= nxt_stl;
               seq_last   <= nxt_stl && (nxt_s == S_MAX);
`ifdef FFT_TWIDDLE_IFFT_EN
               inv_q      <= inverse;
`endif
            end
            RUN: if (out_valid && out_ready) begin
               if (seq_last) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  out_valid  <= 1'b0;
                  done       <= 1'b1;
                  j          <= '0;
                  stage      <= '0;
                  addr_top   <= '0;
                  addr_bot   <= '0;
                  sin_idx    <= '0;
                  cos_idx    <= '0;
                  stage_last <= 1'b0;
                  seq_last   <= 1'b0;
               end else begin
                  j          <= nxt_j;
                  stage      <= nxt_s;
                  addr_top   <= b_top;
                  addr_bot   <= b_bot;
                  sin_idx    <= nxt_sin;
                  cos_idx    <= b_k + QUART;
                  stage_last <= nxt_stl;
                  seq_last   <= nxt_stl && (nxt_s == S_MAX);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   a_stage_range: assert property (@(posedge clk) disable iff (rst) stage < ST_W'(LOG2N));

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Scoreboard + table-driven bench for fft_twiddle_addr_gen.
module tb_fft_twiddle_addr_gen;

   localparam int LOG2N = 6;
   localparam int N     = 64;
   localparam int NB    = 32;
   localparam int NT    = 192;

   typedef struct packed {
      logic [2:0] s;
      logic [5:0] top, bot, sn, cs;
      logic       sl, ql;
   } desc_t;

   typedef struct {
      int s; int j; int top; int bot; int sn; int cs;
   } vec_t;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
`ifdef FFT_TWIDDLE_IFFT_EN
   logic       inverse = 1'b0;
`endif
   logic       busy, out_valid, stage_last, seq_last, done;
   logic [5:0] addr_top, addr_bot, sin_idx, cos_idx;
   logic [2:0] stage;

   fft_twiddle_addr_gen #(.LOG2N(LOG2N), .IDX_W(LOG2N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef FFT_TWIDDLE_IFFT_EN
      .inverse    (inverse),
`endif
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .addr_top   (addr_top),
      .addr_bot   (addr_bot),
      .sin_idx    (sin_idx),
      .cos_idx    (cos_idx),
      .stage      (stage),
      .stage_last (stage_last),
      .seq_last   (seq_last),
      .done       (done)
   );

   always #5 clk = ~clk;

   desc_t dut_d;
   assign dut_d = {stage, addr_top, addr_bot, sin_idx, cos_idx, stage_last, seq_last};

   desc_t exp_q[$];
   desc_t cap[NT];
   vec_t  tbl[6];
   int    nvec = 0, nerr = 0;
   int    nxfer, nstl, nsql, ndone, done_cyc;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic desc_t model(input int s, input int j, input bit inv);
      int    half, pos, base, k;
      desc_t d;
      half = 1 << s;
      pos  = j % half;
      base = (j / half) * 2 * half;
      k    = pos * (N / (2 * half));
      d.s   = 3'(s);
      d.top = 6'(base + pos);
      d.bot = 6'(base + pos + half);
      d.sn  = 6'(inv ? (N - k) % N : k);
      d.cs  = 6'((k + N / 4) % N);
      d.sl  = (j == NB - 1);
      d.ql  = d.sl && (s == LOG2N - 1);
      return d;
   endfunction

   task automatic run_seq(input int ready_pct, input bit inv, input int poke_at, input int rst_at);
      desc_t prev;
      bit    stalled, fin;
      int    c;
      nxfer = 0; nstl = 0; nsql = 0; ndone = 0; done_cyc = -1;
      stalled = 0; fin = 0; prev = '0;
      exp_q.delete();
      @(negedge clk);
      start = 1'b1;
`ifdef FFT_TWIDDLE_IFFT_EN
      inverse = inv;
`endif
      for (int s = 0; s < LOG2N; s++)
         for (int j = 0; j < NB; j++)
            exp_q.push_back(model(s, j, inv));
      @(negedge clk);
      start = 1'b0;
`ifdef FFT_TWIDDLE_IFFT_EN
      inverse = ~inv;
`endif
      c = 1;
      chk("first_valid", out_valid, 1);
      while (!fin && c < 3000) begin
         if (rst_at >= 0 && nxfer == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_clear", {out_valid, busy, done, dut_d}, 0);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_nodone", {out_valid, busy, done, dut_d}, 0);
            exp_q.delete();
            return;
         end
         chk("busy", busy, exp_q.size() != 0);
         chk("valid", out_valid, exp_q.size() != 0);
         chk("done", done, exp_q.size() == 0);
         if (done || exp_q.size() == 0) begin
            if (done) begin
               ndone++;
               done_cyc = c;
            end
            fin = 1;
         end else begin
            if (stalled) chk("hold", dut_d, prev);
            out_ready = ($urandom_range(99) < ready_pct);
            start = (c == poke_at);
            stalled = 0;
            if (out_valid) begin
               chk("desc", dut_d, exp_q[0]);
               stalled = !out_ready;
               prev = dut_d;
               if (out_ready) begin
                  cap[nxfer] = dut_d;
                  nxfer++;
                  nstl += int'(stage_last);
                  nsql += int'(seq_last);
                  void'(exp_q.pop_front());
               end
            end
            @(negedge clk);
            c++;
         end
      end
      if (!fin) chk("timeout", 0, 1);
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse", {done, busy, out_valid}, 0);
   endtask

   initial begin
      tbl[0] = '{0, 5, 10, 11, 0, 16};
      tbl[1] = '{2, 6, 10, 14, 16, 32};
      tbl[2] = '{5, 5, 5, 37, 5, 21};
      tbl[3] = '{1, 3, 5, 7, 16, 32};
      tbl[4] = '{4, 31, 47, 63, 30, 46};
      tbl[5] = '{3, 0, 0, 8, 0, 16};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle", {out_valid, busy, done, dut_d}, 0);
      end

      // full-rate sequence with spot-checked descriptors
      run_seq(100, 0, -1, -1);
      chk("xfers_full", nxfer, NT);
      chk("done_cycle", done_cyc, 193);
      chk("ndone_full", ndone, 1);
      for (int i = 0; i < 6; i++) begin
         desc_t d;
         d = cap[tbl[i].s * NB + tbl[i].j];
         chk("tbl_top", d.top, tbl[i].top);
         chk("tbl_bot", d.bot, tbl[i].bot);
         chk("tbl_sin", d.sn, tbl[i].sn);
         chk("tbl_cos", d.cs, tbl[i].cs);
      end

      // random backpressure
      run_seq(50, 0, -1, -1);
      chk("xfers_bp", nxfer, NT);
      chk("stage_last_cnt", nstl, 6);
      chk("seq_last_cnt", nsql, 1);
      chk("ndone_bp", ndone, 1);

      // start pulsed mid-run is ignored
      run_seq(70, 0, 40, -1);
      chk("xfers_poke", nxfer, NT);
      chk("ndone_poke", ndone, 1);

      // reset abort at transfer 100, then a clean replay
      run_seq(100, 0, -1, 100);
      run_seq(100, 0, -1, -1);
      chk("xfers_replay", nxfer, NT);
      chk("done_cycle_replay", done_cyc, 193);

`ifdef FFT_TWIDDLE_IFFT_EN
      run_seq(100, 1, -1, -1);
      chk("xfers_inv", nxfer, NT);
      chk("inv_sin_s5j5", cap[5 * NB + 5].sn, 59);
      chk("inv_cos_s5j5", cap[5 * NB + 5].cs, 21);
      chk("inv_sin_s0j7", cap[7].sn, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
